// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// A read and a write to the same address on the same edge return the old data.
module simple_dual_port_ram #(
  parameter int    Dw         = 8,
  parameter int    Aw         = 4,
  parameter string INITIAL_EN = "NO"
) (
  input  logic          clk,
  input  logic          we,
  input  logic [Aw-1:0] write_addr,
  input  logic [Dw-1:0] data,
  input  logic [Aw-1:0] read_addr,
  output logic [Dw-1:0] q
);

  logic [Dw-1:0] mem [2**Aw];

  // Preloaded contents are not provided; reject any other setting at elaboration.
  if (INITIAL_EN != "NO") begin : g_init_check
    $error("simple_dual_port_ram: only INITIAL_EN=\"NO\" is supported");
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[write_addr] <= data;
    end
    q <= mem[read_addr];
  end

endmodule

// File: rtl/sdp_fwft_fifo.sv
// First-word-fall-through FIFO over a registered-read dual-port RAM.
// The RAM read address looks ahead by the pop so q always holds the head after the edge.
module sdp_fwft_fifo #(
  parameter int Dw = 8,
  parameter int Aw = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [Dw-1:0] din,
  input  logic          rd_en,
  output logic [Dw-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [Aw:0]   count
);

  localparam int DEPTH = 2**Aw;

  logic [Aw-1:0] wr_ptr;
  logic [Aw-1:0] rd_ptr;
  logic [Aw-1:0] read_addr;
  logic [Aw:0]   vis_count;
  logic          push_d;
  logic          push;
  logic          pop;
  logic [Dw-1:0] q;

  assign empty = (vis_count == '0);
  assign full  = (count == (Aw+1)'(DEPTH));
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign read_addr = rd_ptr + Aw'(pop);
  assign dout      = empty ? '0 : q;

  simple_dual_port_ram #(
    .Dw         (Dw),
    .Aw         (Aw),
    .INITIAL_EN ("NO")
  ) u_ram (
    .clk        (clk),
    .we         (push),
    .write_addr (wr_ptr),
    .data       (din),
    .read_addr  (read_addr),
    .q          (q)
  );

  // An entry written this edge cannot be read back until the next edge (old data
  // on collision), so visibility trails the stored count by one cycle via push_d.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      vis_count <= '0;
      push_d    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count + (Aw+1)'(push) - (Aw+1)'(pop);
      vis_count <= vis_count + (Aw+1)'(push_d) - (Aw+1)'(pop);
      push_d    <= push;
    end
  end

endmodule

// File: tb/tb_sdp_fwft_fifo.sv
// Directed bench for sdp_fwft_fifo with Dw=8, Aw=2 (four entries).
module tb_sdp_fwft_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  sdp_fwft_fifo #(.Dw(8), .Aw(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .din     (din),
    .rd_en   (rd_en),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0] exp_q[$];
    logic [7:0] next_val;
    int         popped;
    logic       saw_05;

    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = 8'h00;
    tick();
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    reset_n = 1'b1;
    tick();

    // Write-to-empty latency
    wr_en = 1'b1; din = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("w2e_count_e1", 32'(count), 32'd1);
    chk("w2e_empty_e1", 32'(empty), 32'd1);
    chk("w2e_dout_e1",  32'(dout),  32'd0);
    tick();
    chk("w2e_empty_e2", 32'(empty), 32'd0);
    chk("w2e_dout_e2",  32'(dout),  32'hA5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("w2e_pop_empty", 32'(empty), 32'd1);
    chk("w2e_pop_count", 32'(count), 32'd0);
    chk("w2e_pop_dout",  32'(dout),  32'd0);

    // Pop while empty is ignored; simultaneous push still lands
    rd_en = 1'b1;
    tick();
    chk("uflow_count", 32'(count), 32'd0);
    wr_en = 1'b1; din = 8'h77;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("uflow_push_count", 32'(count), 32'd1);
    chk("uflow_push_empty", 32'(empty), 32'd1);
    tick();
    chk("uflow_push_dout", 32'(dout), 32'h77);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("uflow_drain", 32'(count), 32'd0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; din = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_head", 32'(dout), 32'h01);
    din = 8'h05;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_full",  32'(full),  32'd1);
    rd_en = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("drain_dout",  32'(dout),  32'(i));
      chk("drain_count", 32'(count), 32'(4 - i + 1));
      chk("drain_full",  32'(full),  32'd0);
    end
    tick();
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_cnt0",  32'(count), 32'd0);

    // Simultaneous push+pop at full
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; din = 8'h21 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_head", 32'(dout), 32'h21);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h05;
    tick();
    wr_en = 1'b0;
    chk("pp_count", 32'(count), 32'd3);
    chk("pp_full2", 32'(full),  32'd0);
    chk("pp_dout",  32'(dout),  32'h22);
    saw_05 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dout == 8'h05) saw_05 = 1'b1;
      if (!empty) tick();
    end
    rd_en = 1'b0;
    chk("pp_no05",  32'(saw_05), 32'd0);
    chk("pp_empty", 32'(empty),  32'd1);
    chk("pp_cnt0",  32'(count),  32'd0);

    // Reset mid-cycle while holding three entries
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'h31 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("mrst_pre_count", 32'(count), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full",  32'(full),  32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_dout",  32'(dout),  32'd0);
    tick();
    reset_n = 1'b1;
    wr_en = 1'b1; din = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("mrst_e1_empty", 32'(empty), 32'd1);
    chk("mrst_e1_dout",  32'(dout),  32'd0);
    tick();
    chk("mrst_e2_empty", 32'(empty), 32'd0);
    chk("mrst_e2_dout",  32'(dout),  32'h11);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;

    // Streaming across pointer wrap
    next_val = 8'h40;
    popped   = 0;
    for (int c = 0; c < 20; c++) begin
      wr_en = 1'b1;
      din   = next_val;
      rd_en = !empty;
      if (!empty) begin
        chk("stream_dout", 32'(dout), 32'(exp_q.pop_front()));
        popped++;
      end
      if (!full) exp_q.push_back(next_val);
      next_val++;
      tick();
      chk("stream_cnt_le2", 32'(count <= 3'd2), 32'd1);
    end
    wr_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rd_en = !empty;
      if (!empty) begin
        chk("stream_tail", 32'(dout), 32'(exp_q.pop_front()));
        popped++;
      end
      tick();
    end
    rd_en = 1'b0;
    chk("stream_popped", 32'(popped), 32'd20);
    chk("stream_left",   32'(exp_q.size()), 32'd0);
    chk("stream_empty",  32'(empty), 32'd1);
    chk("stream_cnt0",   32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
